// File: rtl/serial_word_deserializer.sv
// Framed serial-to-parallel receiver: assembles WIDTH-bit words (MSB- or LSB-first) behind a valid/ready output register.
// Optional trailing even-parity bit per word: define SERIAL_WORD_DESERIALIZER_PARITY_EN.
module serial_word_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             msb_first,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             word_ready,
  input  logic             err_clr,
  output logic             word_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_perr,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             msb_q, msb_d;
  logic             done;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
  logic             perr_new;
`endif

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] acc,
                                                 input logic msb, input logic b);
    if (msb) return {acc[WIDTH-2:0], b};
    return {b, acc[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
    end
  end

  // start wins over everything and restarts the frame; a coincident bit becomes bit 0
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    msb_d    = msb_q;
    done     = 1'b0;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
    perr_new = 1'b0;
`endif
    if (start) begin
      state_d = DATA;
      msb_d   = msb_first;
      cnt_d   = '0;
      if (bit_valid) begin
        acc_d = shift_in(acc_q, msb_first, bit_in);
        cnt_d = CW'(1);
      end
    end else if (bit_valid) begin
      case (state_q)
        DATA: begin
          acc_d = shift_in(acc_q, msb_q, bit_in);
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d = '0;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            done = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
        PARITY: begin
          done     = 1'b1;
          perr_new = ^{acc_q, bit_in};
          state_d  = DATA;
        end
`endif
        default: ;
      endcase
    end
  end

  // Output register: a completion is dropped (and flagged) only if the held word is not being consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_valid <= 1'b0;
      word_out   <= '0;
      overrun    <= 1'b0;
    end else begin
      if (done) begin
        if (!word_valid || word_ready) begin
          word_valid <= 1'b1;
          word_out   <= acc_d;
        end
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
      if (done && word_valid && !word_ready) overrun <= 1'b1;
      else if (err_clr)                      overrun <= 1'b0;
    end
  end

`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  word_perr <= 1'b0;
    else if (done && (!word_valid || word_ready)) word_perr <= perr_new;
  end
`else
  assign word_perr = 1'b0;
`endif

  assign busy = (state_q != IDLE);

endmodule
